// File: rtl/dat_frame_writer.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : dat_frame_writer
//  Purpose  : Sink-side framer for .dat file dumping. Buffers a DUT sample
//             stream in a FIFO, groups samples into frames and emits each
//             frame as one header word followed by its data words on a
//             valid/ready output. A flush pulse closes a partial frame.
//  Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Ports
//    i_clk        in   1        single clock, rising edge
//    i_rst        in   1        asynchronous reset, active-high
//    s_data       in   DATA_WD  input sample
//    s_valid      in   1        sample valid
//    s_ready      out  1        sample accepted when s_valid && s_ready
//    i_flush      in   1        1-cycle pulse: close current partial frame
//    m_data       out  32       header {A55A, frame_idx} or zero-ext sample
//    m_valid      out  1        output word valid
//    m_ready      in   1        consumer ready
//    m_hdr        out  1        m_data is a header word
//    m_last       out  1        m_data is the final data word of its frame
//    o_frame_cnt  out  16       completed frames (wraps)
//    o_level      out  AW+1     FIFO occupancy
// ============================================================================
module dat_frame_writer #(
  parameter int DATA_WD    = 16,
  parameter int FRAME_LEN  = 8,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                          i_clk,
  input  logic                          i_rst,
  input  logic [DATA_WD-1:0]            s_data,
  input  logic                          s_valid,
  output logic                          s_ready,
  input  logic                          i_flush,
  output logic [31:0]                   m_data,
  output logic                          m_valid,
  input  logic                          m_ready,
  output logic                          m_hdr,
  output logic                          m_last,
  output logic [15:0]                   o_frame_cnt,
  output logic [$clog2(FIFO_DEPTH):0]   o_level
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;
  localparam int EW = DATA_WD + 1;
  localparam logic [CW-1:0] C_LAST_IDX = CW'(FRAME_LEN - 1);
  localparam logic [AW:0]   C_DEPTH    = (AW + 1)'(FIFO_DEPTH);
  localparam logic [15:0]   C_HDR_TAG  = 16'hA55A;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HDR  = 2'd1,
    ST_DATA = 2'd2
  } state_t;

  // FIFO storage: entry = {end_tag, sample}
  logic [EW-1:0]      mem_q [FIFO_DEPTH];
  logic [AW:0]        wr_ptr_q, wr_ptr_d;
  logic [AW:0]        rd_ptr_q, rd_ptr_d;
  logic [AW:0]        level;
  logic               full, empty;

  logic [CW-1:0]      in_cnt_q, in_cnt_d;
  logic               flush_pend_q, flush_pend_d;
  state_t             state_q, state_d;
  logic [15:0]        frame_idx_q, frame_idx_d;

  logic               accept, pad_wr, push, pop;
  logic [EW-1:0]      wr_entry;
  logic [EW-1:0]      head;
  logic               head_tag;
  logic [DATA_WD-1:0] head_sample;

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  assign level   = wr_ptr_q - rd_ptr_q;
  assign full    = (level == C_DEPTH);
  assign empty   = (level == '0);

  // A pending flush blocks new samples until its pad entry has been written,
  // so the pad always lands directly behind the partial frame it closes.
  assign s_ready = !i_rst && !full && !flush_pend_q;
  assign accept  = s_valid && s_ready;
  assign pad_wr  = flush_pend_q && !full;
  assign push    = accept || pad_wr;

  assign head        = mem_q[rd_ptr_q[AW-1:0]];
  assign head_tag    = head[DATA_WD];
  assign head_sample = head[DATA_WD-1:0];

  // --------------------------------------------------------------------------
  // Input side: frame counting, end tagging and flush handling
  // --------------------------------------------------------------------------
  always_comb begin
    in_cnt_d     = in_cnt_q;
    flush_pend_d = flush_pend_q;
    wr_entry     = {1'b0, s_data};
    if (accept) begin
      if ((in_cnt_q == C_LAST_IDX) || i_flush) begin
        wr_entry = {1'b1, s_data};
        in_cnt_d = '0;
      end else begin
        in_cnt_d = in_cnt_q + CW'(1);
      end
    end else if (pad_wr) begin
      // Zero pad entry closes the partial frame.
      wr_entry     = {1'b1, {DATA_WD{1'b0}}};
      in_cnt_d     = '0;
      flush_pend_d = 1'b0;
    end else if (i_flush && !flush_pend_q && (in_cnt_q != '0)) begin
      flush_pend_d = 1'b1;
    end
  end

  assign wr_ptr_d = push ? (wr_ptr_q + (AW + 1)'(1)) : wr_ptr_q;
  assign rd_ptr_d = pop  ? (rd_ptr_q + (AW + 1)'(1)) : rd_ptr_q;

  // --------------------------------------------------------------------------
  // Output side: words are decoded from registered state and the FIFO head
  // only, so m_ready never reaches m_valid/m_data combinationally.
  // --------------------------------------------------------------------------
  always_comb begin
    m_valid = 1'b0;
    m_hdr   = 1'b0;
    m_last  = 1'b0;
    m_data  = '0;
    case (state_q)
      ST_HDR: begin
        m_valid = 1'b1;
        m_hdr   = 1'b1;
        m_data  = {C_HDR_TAG, frame_idx_q};
      end
      ST_DATA: begin
        m_valid = !empty;
        m_last  = !empty && head_tag;
        m_data  = empty ? 32'd0 : 32'(head_sample);
      end
      default: ;
    endcase
  end

  assign pop = (state_q == ST_DATA) && !empty && m_ready;

  always_comb begin
    state_d     = state_q;
    frame_idx_d = frame_idx_q;
    case (state_q)
      ST_IDLE: if (!empty) state_d = ST_HDR;
      ST_HDR:  if (m_ready) state_d = ST_DATA;
      ST_DATA: begin
        if (pop && head_tag) begin
          state_d     = ST_IDLE;
          frame_idx_d = frame_idx_q + 16'd1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      in_cnt_q     <= '0;
      flush_pend_q <= 1'b0;
      state_q      <= ST_IDLE;
      frame_idx_q  <= '0;
    end else begin
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      in_cnt_q     <= in_cnt_d;
      flush_pend_q <= flush_pend_d;
      state_q      <= state_d;
      frame_idx_q  <= frame_idx_d;
    end
  end

  // Storage needs no reset: occupancy is tracked by the pointers alone.
  always_ff @(posedge i_clk) begin
    if (push) begin
      mem_q[wr_ptr_q[AW-1:0]] <= wr_entry;
    end
  end

  // Every popped end tag completes a frame, so the header index doubles as
  // the completed-frame counter.
  assign o_frame_cnt = frame_idx_q;
  assign o_level     = level;

endmodule
`default_nettype wire

// File: tb/tb_dat_frame_writer.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : tb_dat_frame_writer
//  Purpose  : Self-checking bench for dat_frame_writer. Directed scenarios
//             plus a randomized phase, compared against a word-level
//             reference model of the framed output stream.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_dat_frame_writer;

  localparam int DATA_WD    = 16;
  localparam int FRAME_LEN  = 8;
  localparam int FIFO_DEPTH = 16;

  logic        i_clk   = 1'b0;
  logic        i_rst   = 1'b1;
  logic [15:0] s_data  = '0;
  logic        s_valid = 1'b0;
  logic        s_ready;
  logic        i_flush = 1'b0;
  logic [31:0] m_data;
  logic        m_valid;
  logic        m_ready = 1'b0;
  logic        m_hdr;
  logic        m_last;
  logic [15:0] o_frame_cnt;
  logic [4:0]  o_level;

  dat_frame_writer #(
    .DATA_WD    (DATA_WD),
    .FRAME_LEN  (FRAME_LEN),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) dut (
    .i_clk       (i_clk),
    .i_rst       (i_rst),
    .s_data      (s_data),
    .s_valid     (s_valid),
    .s_ready     (s_ready),
    .i_flush     (i_flush),
    .m_data      (m_data),
    .m_valid     (m_valid),
    .m_ready     (m_ready),
    .m_hdr       (m_hdr),
    .m_last      (m_last),
    .o_frame_cnt (o_frame_cnt),
    .o_level     (o_level)
  );

  always #5 i_clk = ~i_clk;

  int checks   = 0;
  int failures = 0;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reference model: the expected output word stream plus buffer bookkeeping.
  typedef struct packed {
    logic        hdr;
    logic        last;
    logic [31:0] data;
  } word_t;

  word_t       exp_q[$];
  int          m_lvl;
  bit          m_pend;
  int          m_len;
  logic [15:0] m_idx;
  logic [15:0] m_fcnt;
  int          cyc = 0;
  int          first_hdr_cyc;
  int          first_dat_cyc;

  task automatic model_reset();
    exp_q.delete();
    m_lvl  = 0;
    m_pend = 0;
    m_len  = 0;
    m_idx  = 16'h0000;
    m_fcnt = 16'h0000;
  endtask

  // A sample opening a new frame first queues that frame's header.
  task automatic model_push(input logic [15:0] smp, input bit tag);
    word_t w;
    if (m_len == 0) begin
      w.hdr  = 1'b1;
      w.last = 1'b0;
      w.data = {16'hA55A, m_idx};
      exp_q.push_back(w);
      m_idx = m_idx + 16'd1;
    end
    w.hdr  = 1'b0;
    w.last = tag;
    w.data = {16'h0000, smp};
    exp_q.push_back(w);
    m_lvl++;
    m_len = tag ? 0 : m_len + 1;
  endtask

  // One clock cycle: drive at the falling edge, check 1ns later, advance.
  task automatic step(input bit sv, input logic [15:0] sd, input bit fl, input bit mr);
    bit    exp_rdy;
    int    lvl_pre;
    word_t w;
    s_valid = sv;
    s_data  = sd;
    i_flush = fl;
    m_ready = mr;
    #1;
    lvl_pre = m_lvl;
    exp_rdy = (m_lvl < FIFO_DEPTH) && !m_pend;
    check_val("s_ready", 32'(s_ready), 32'(exp_rdy));
    check_val("o_level", 32'(o_level), 32'(m_lvl));
    check_val("o_frame_cnt", 32'(o_frame_cnt), 32'(m_fcnt));
    if (exp_q.size() == 0) begin
      check_val("m_valid_idle", 32'(m_valid), 32'd0);
    end else if (m_valid && mr) begin
      w = exp_q.pop_front();
      check_val("m_data", m_data, w.data);
      check_val("m_hdr", 32'(m_hdr), 32'(w.hdr));
      check_val("m_last", 32'(m_last), 32'(w.last));
      if (w.hdr) begin
        if (first_hdr_cyc < 0) first_hdr_cyc = cyc;
      end else begin
        if (first_dat_cyc < 0) first_dat_cyc = cyc;
        m_lvl--;
        if (w.last) m_fcnt = m_fcnt + 16'd1;
      end
    end
    if (sv && exp_rdy) begin
      model_push(sd, (m_len == FRAME_LEN - 1) || fl);
    end else if (m_pend && lvl_pre < FIFO_DEPTH) begin
      model_push(16'h0000, 1'b1);
      m_pend = 0;
    end else if (fl && !m_pend && m_len > 0) begin
      m_pend = 1;
    end
    @(negedge i_clk);
    cyc++;
  endtask

  task automatic drain();
    for (int i = 0; i < 300; i++) begin
      if (exp_q.size() == 0 && m_lvl == 0 && !m_pend) break;
      step(1'b0, 16'h0000, 1'b0, 1'b1);
    end
    check_val("drain_words_left", 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    int acc_cyc;
    model_reset();
    first_hdr_cyc = -1;
    first_dat_cyc = -1;

    // Reset state
    repeat (3) @(negedge i_clk);
    check_val("rst_s_ready", 32'(s_ready), 32'd0);
    check_val("rst_m_valid", 32'(m_valid), 32'd0);
    check_val("rst_m_data", m_data, 32'd0);
    check_val("rst_o_level", 32'(o_level), 32'd0);
    check_val("rst_frame_cnt", 32'(o_frame_cnt), 32'd0);
    i_rst = 1'b0;

    // 1) Full frame 1..8, latency header T+2, first sample T+3
    acc_cyc = cyc;
    for (int i = 1; i <= 8; i++) step(1'b1, 16'(i), 1'b0, 1'b1);
    drain();
    check_val("t1_hdr_latency", 32'(first_hdr_cyc - acc_cyc), 32'd2);
    check_val("t1_dat_latency", 32'(first_dat_cyc - acc_cyc), 32'd3);
    check_val("t1_frame_cnt", 32'(o_frame_cnt), 32'd1);

    // 2) Three samples then a lone flush: pad word closes the frame
    for (int i = 0; i < 3; i++) step(1'b1, 16'h0100 + 16'(i), 1'b0, 1'b1);
    step(1'b0, 16'h0000, 1'b1, 1'b1);
    #1;
    check_val("t2_s_ready_low", 32'(s_ready), 32'd0);
    step(1'b0, 16'h0000, 1'b0, 1'b1);
    check_val("t2_s_ready_back", 32'(s_ready), 32'd1);
    drain();

    // 3) Flush together with the 5th sample: that sample ends the frame
    for (int i = 0; i < 4; i++) step(1'b1, 16'h0200 + 16'(i), 1'b0, 1'b1);
    step(1'b1, 16'h0204, 1'b1, 1'b1);
    drain();
    check_val("t3_frame_cnt", 32'(o_frame_cnt), 32'd3);

    // 4) Backpressure: only FIFO_DEPTH of 20 samples get in
    for (int i = 0; i < 20; i++) step(1'b1, 16'h0300 + 16'(i), 1'b0, 1'b0);
    #1;
    check_val("t4_level_full", 32'(o_level), 32'd16);
    check_val("t4_s_ready_full", 32'(s_ready), 32'd0);
    drain();

    // 5) Header index wrap FFFF -> 0000
    force dut.frame_idx_q = 16'hFFFF;
    m_idx  = 16'hFFFF;
    m_fcnt = 16'hFFFF;
    step(1'b0, 16'h0000, 1'b0, 1'b1);
    release dut.frame_idx_q;
    for (int i = 0; i < 8; i++) step(1'b1, 16'h0400 + 16'(i), 1'b0, 1'b1);
    drain();
    check_val("t5_frame_cnt_wrap", 32'(o_frame_cnt), 32'd0);
    for (int i = 0; i < 8; i++) step(1'b1, 16'h0500 + 16'(i), 1'b0, 1'b1);
    drain();

    // 6) Reset mid-frame with five buffered samples
    for (int i = 0; i < 5; i++) step(1'b1, 16'h0600 + 16'(i), 1'b0, 1'b0);
    #1;
    check_val("t6_level_before", 32'(o_level), 32'd5);
    s_valid = 1'b0;
    #1;
    i_rst = 1'b1;
    #1;
    check_val("t6_m_valid", 32'(m_valid), 32'd0);
    check_val("t6_m_data", m_data, 32'd0);
    check_val("t6_m_hdr_last", {30'd0, m_hdr, m_last}, 32'd0);
    check_val("t6_o_level", 32'(o_level), 32'd0);
    check_val("t6_frame_cnt", 32'(o_frame_cnt), 32'd0);
    check_val("t6_s_ready", 32'(s_ready), 32'd0);
    @(negedge i_clk);
    i_rst = 1'b0;
    model_reset();
    for (int i = 0; i < 8; i++) step(1'b1, 16'h0700 + 16'(i), 1'b0, 1'b1);
    drain();

    // Randomized traffic with backpressure and sporadic flushes
    for (int i = 0; i < 1500; i++) begin
      step(($urandom % 10) < 7, 16'($urandom), ($urandom % 20) == 0, ($urandom % 3) != 0);
    end
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
